// File: rtl/spi_arbiter.sv
// spi_arbiter: two-port arbiter that shares one SPI flash byte engine and chip select.
// Outputs are registered from the next state, so they line up with the state they describe.
module spi_arbiter #(
    parameter int XFER_CYCLES = 18,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_wr,
    input  logic       a_hold,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_done,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_wr,
    input  logic       b_hold,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_done,
    output logic [7:0] b_rdata,
    output logic       eng_send,
    output logic       eng_recv,
    output logic [7:0] eng_wdata,
    input  logic [7:0] eng_rdata,
    output logic       spi_cs_n,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SETUP, XFER, DONE, HOLD, GAP} state_t;
    state_t     state, nxt;
    logic       own_b, nxt_own_b, last_b, wr_q, hold_q;
    logic [7:0] cnt, nxt_cnt;
    logic       d_cs_n, d_a_gnt, d_b_gnt, d_send, d_recv, d_a_done, d_b_done, d_busy, ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            own_b     <= 1'b0;
            last_b    <= 1'b1;
            wr_q      <= 1'b0;
            hold_q    <= 1'b0;
            eng_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            spi_cs_n  <= 1'b1;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            eng_send  <= 1'b0;
            eng_recv  <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= nxt_cnt;
            own_b <= nxt_own_b;
            if (state == GAP) last_b <= own_b;
            // byte parameters are captured on entry to SETUP, from the port that owns the bus
            if (ld) begin
                wr_q      <= nxt_own_b ? b_wr : a_wr;
                hold_q    <= nxt_own_b ? b_hold : a_hold;
                eng_wdata <= nxt_own_b ? b_wdata : a_wdata;
            end
            if (d_a_done) a_rdata <= eng_rdata;
            if (d_b_done) b_rdata <= eng_rdata;
            spi_cs_n <= d_cs_n;
            a_gnt    <= d_a_gnt;
            b_gnt    <= d_b_gnt;
            eng_send <= d_send;
            eng_recv <= d_recv;
            a_done   <= d_a_done;
            b_done   <= d_b_done;
            busy     <= d_busy;
        end
    end

    always_comb begin
        nxt       = state;
        nxt_own_b = own_b;
        nxt_cnt   = cnt;
        case (state)
            IDLE: if (a_req || b_req) begin
                nxt       = SETUP;
                nxt_own_b = b_req && (!a_req || !last_b);
            end
            SETUP: begin
                nxt     = XFER;
                nxt_cnt = '0;
            end
            XFER: if (cnt == 8'(XFER_CYCLES - 1)) nxt = DONE;
                  else nxt_cnt = cnt + 8'd1;
            DONE: begin
                nxt     = hold_q ? HOLD : GAP;
                nxt_cnt = '0;
            end
            HOLD: if (own_b ? b_req : a_req) nxt = SETUP;
            GAP:  if (cnt == 8'(CS_GAP - 1)) nxt = IDLE;
                  else nxt_cnt = cnt + 8'd1;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        d_cs_n   = !(nxt inside {SETUP, XFER, DONE, HOLD});
        d_a_gnt  = !d_cs_n && !nxt_own_b;
        d_b_gnt  = !d_cs_n && nxt_own_b;
        d_send   = nxt == XFER && wr_q;
        d_recv   = nxt == XFER && !wr_q;
        d_a_done = nxt == DONE && !nxt_own_b;
        d_b_done = nxt == DONE && nxt_own_b;
        d_busy   = nxt != IDLE;
        ld       = nxt == SETUP;
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized bench for spi_arbiter, checked cycle by cycle against a
// transaction schedule computed from request times, byte counts and the fixed phase lengths.
module tb_spi_arbiter;
    localparam int X  = 18;
    localparam int G  = 4;

    typedef struct {
        bit         wr;
        logic [7:0] wd;
        logic [7:0] rd;
    } tmpl_t;

    typedef struct {
        bit         p;
        bit         wr;
        bit         hold;
        logic [7:0] wd;
        logic [7:0] rd;
        int         s;
        int         drop;
    } byte_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a_req = 1'b0, a_wr = 1'b0, a_hold = 1'b0;
    logic b_req = 1'b0, b_wr = 1'b0, b_hold = 1'b0;
    logic [7:0] a_wdata = '0, b_wdata = '0, eng_rdata = '0;
    logic a_gnt, a_done, b_gnt, b_done, eng_send, eng_recv, spi_cs_n, busy;
    logic [7:0] a_rdata, b_rdata, eng_wdata;

    logic f_a_req = 1'b0, f_a_wr = 1'b0, f_a_hold = 1'b0;
    logic f_b_req = 1'b0, f_b_wr = 1'b0, f_b_hold = 1'b0;
    logic [7:0] f_a_wdata = '0, f_b_wdata = '0, f_eng_rdata = '0;
    logic f_a_gnt, f_a_done, f_b_gnt, f_b_done, f_eng_send, f_eng_recv, f_spi_cs_n, f_busy;
    logic [7:0] f_a_rdata, f_b_rdata, f_eng_wdata;

    int checks = 0;
    int errors = 0;
    bit last_b = 1'b1;
    logic [7:0] exp_ra = '0, exp_rb = '0;
    tmpl_t qa[$], qb[$];

    always #5 clk = ~clk;

    spi_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_hold(a_hold), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_hold(b_hold), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .eng_send(eng_send), .eng_recv(eng_recv), .eng_wdata(eng_wdata), .eng_rdata(eng_rdata),
        .spi_cs_n(spi_cs_n), .busy(busy)
    );

    spi_arbiter #(.XFER_CYCLES(17), .CS_GAP(1)) fast (
        .clk(clk), .rst_n(rst_n),
        .a_req(f_a_req), .a_wr(f_a_wr), .a_hold(f_a_hold), .a_wdata(f_a_wdata),
        .a_gnt(f_a_gnt), .a_done(f_a_done), .a_rdata(f_a_rdata),
        .b_req(f_b_req), .b_wr(f_b_wr), .b_hold(f_b_hold), .b_wdata(f_b_wdata),
        .b_gnt(f_b_gnt), .b_done(f_b_done), .b_rdata(f_b_rdata),
        .eng_send(f_eng_send), .eng_recv(f_eng_recv), .eng_wdata(f_eng_wdata), .eng_rdata(f_eng_rdata),
        .spi_cs_n(f_spi_cs_n), .busy(f_busy)
    );

    function automatic tmpl_t rnd();
        tmpl_t t;
        t.wr = 1'($urandom);
        t.wd = 8'($urandom);
        t.rd = 8'($urandom);
        return t;
    endfunction

    task automatic drive(input bit p, input bit rq, input byte_t b);
        if (p) begin
            b_req = rq; b_wr = b.wr; b_hold = b.hold; b_wdata = b.wd;
        end else begin
            a_req = rq; a_wr = b.wr; a_hold = b.hold; a_wdata = b.wd;
        end
    endtask

    // Bytes queued in qa/qb form one burst per port; ra/rb are the cycles req rises (-1: none).
    task automatic run_round(input int ra, input int rb, input bit drop_ok, input string tag);
        byte_t      q[$];
        byte_t      bt;
        tmpl_t      tp;
        int         r[2];
        int         c, s, d, dn, t_end;
        bit         fp, p, chk_w;
        logic [7:0] exp_v, got_v, ew;
        r[0] = ra;
        r[1] = rb;
        fp = (ra >= 0 && rb >= 0) ? ((ra == rb) ? !last_b : (rb < ra)) : (ra < 0);
        d = 0;
        for (int o = 0; o < 2; o++) begin
            p = (o == 0) ? fp : !fp;
            if (r[p] < 0) continue;
            c = (o == 0 || r[p] > d + G + 1) ? r[p] : d + G + 1;
            s = c + 1;
            while ((p ? qb.size() : qa.size()) > 0) begin
                tp = p ? qb.pop_front() : qa.pop_front();
                bt.p = p; bt.wr = tp.wr; bt.wd = tp.wd; bt.rd = tp.rd; bt.s = s;
                bt.hold = (p ? qb.size() : qa.size()) > 0;
                d = s + X + 1;
                bt.drop = (drop_ok && !bt.hold) ? int'($urandom_range(d, s + 1)) : d;
                q.push_back(bt);
                s = d + 2;
            end
            last_b = p;
        end
        t_end = d + G + 3;
        for (int t = 0; t <= t_end; t++) begin
            eng_rdata = 8'($urandom);
            foreach (q[i]) begin
                dn = q[i].s + X + 1;
                if (t == r[q[i].p] && (i == 0 || q[i-1].p != q[i].p)) drive(q[i].p, 1'b1, q[i]);
                if (t == dn && q[i].hold) drive(q[i].p, 1'b1, q[i+1]);
                if (t == q[i].drop && !q[i].hold) drive(q[i].p, 1'b0, q[i]);
                if (t == dn - 1) eng_rdata = q[i].rd;
            end
            // bit order: a_gnt b_gnt cs_n send recv a_done b_done busy
            exp_v = 8'b0010_0000;
            chk_w = 1'b0;
            ew = '0;
            foreach (q[i]) begin
                dn = q[i].s + X + 1;
                if (t >= q[i].s && t <= dn + int'(q[i].hold)) begin
                    exp_v[7 - q[i].p] = 1'b1;
                    exp_v[5] = 1'b0;
                end
                if (t >= q[i].s && t <= dn + (q[i].hold ? 1 : G)) exp_v[0] = 1'b1;
                if (t > q[i].s && t < dn) begin
                    exp_v[q[i].wr ? 4 : 3] = 1'b1;
                    chk_w = 1'b1;
                    ew = q[i].wd;
                end
                if (t == dn) begin
                    exp_v[2 - q[i].p] = 1'b1;
                    if (q[i].p) exp_rb = q[i].rd;
                    else exp_ra = q[i].rd;
                end
            end
            got_v = {a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s outputs t=%0d got %b expected %b (gA gB csn snd rcv dA dB bsy)", tag, t, got_v, exp_v);
            end
            checks++;
            if ({a_rdata, b_rdata} !== {exp_ra, exp_rb}) begin
                errors++;
                $display("FAIL %s rdata t=%0d got a=%h b=%h expected a=%h b=%h", tag, t, a_rdata, b_rdata, exp_ra, exp_rb);
            end
            if (chk_w) begin
                checks++;
                if (eng_wdata !== ew) begin
                    errors++;
                    $display("FAIL %s eng_wdata t=%0d got %h expected %h", tag, t, eng_wdata, ew);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy} !== 8'b0010_0000) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00100000",
                     {a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy});
        end
        checks++;
        if ({a_rdata, b_rdata, eng_wdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h expected 000000", {a_rdata, b_rdata, eng_wdata});
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy} !== 8'b0010_0000) begin
            errors++;
            $display("FAIL reset_release got %b expected 00100000",
                     {a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy});
        end
        last_b = 1'b1;
    endtask

    task automatic test_write_a5();
        qa.push_back(tmpl_t'{1'b1, 8'hA5, 8'($urandom)});
        run_round(0, -1, 1'b0, "write_a5");
    endtask

    task automatic test_tie();
        qa.push_back(rnd());
        qb.push_back(rnd());
        run_round(0, 0, 1'b0, "tie");
    endtask

    task automatic test_hold_seq();
        qb.push_back(tmpl_t'{1'b1, 8'h03, 8'($urandom)});
        qb.push_back(tmpl_t'{1'b0, 8'($urandom), 8'h11});
        qb.push_back(tmpl_t'{1'b0, 8'($urandom), 8'h22});
        qb.push_back(tmpl_t'{1'b0, 8'($urandom), 8'h33});
        qa.push_back(rnd());
        run_round(30, 0, 1'b0, "hold_seq");
        checks++;
        if (b_rdata !== 8'h33) begin
            errors++;
            $display("FAIL hold_seq_final b_rdata got %h expected 33", b_rdata);
        end
    endtask

    task automatic test_mid_reset();
        a_req = 1'b1; a_wr = 1'b0; a_hold = 1'b0; a_wdata = 8'($urandom);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (eng_recv !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_strobe eng_recv got %b expected 1", eng_recv);
        end
        a_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy} !== 8'b0010_0000) begin
            errors++;
            $display("FAIL mid_reset_async got %b expected 00100000",
                     {a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_b = 1'b1;
        exp_ra = '0;
        exp_rb = '0;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if ({a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy, a_rdata, b_rdata} !==
                {8'b0010_0000, exp_ra, exp_rb}) begin
                errors++;
                $display("FAIL mid_reset_quiet i=%0d got %b expected idle with zero rdata", i,
                         {a_gnt, b_gnt, spi_cs_n, eng_send, eng_recv, a_done, b_done, busy, a_rdata, b_rdata});
            end
            @(posedge clk);
            #1;
        end
        qa.push_back(rnd());
        qb.push_back(rnd());
        run_round(0, 0, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int ra, rb, m;
            m = int'($urandom_range(2, 0));
            ra = (m == 1) ? -1 : int'($urandom_range(3, 0));
            rb = (m == 0) ? -1 : int'($urandom_range(3, 0));
            if (ra >= 0) repeat ($urandom_range(3, 1)) qa.push_back(rnd());
            if (rb >= 0) repeat ($urandom_range(3, 1)) qb.push_back(rnd());
            run_round(ra, rb, 1'($urandom), "random");
        end
    endtask

    // XFER_CYCLES=17, CS_GAP=1: A done at 19, one GAP clock, IDLE, then B from cycle 22 to done at 40.
    task automatic test_fast_gap();
        logic [5:0] ev, gv;
        f_eng_rdata = 8'($urandom);
        f_a_req = 1'b1; f_a_wr = 1'b1; f_a_wdata = 8'($urandom);
        f_b_req = 1'b1; f_b_wr = 1'b0;
        for (int t = 0; t <= 45; t++) begin
            if (t == 19) f_a_req = 1'b0;
            if (t == 40) f_b_req = 1'b0;
            ev[5] = t >= 1 && t <= 19;
            ev[4] = t >= 22 && t <= 40;
            ev[3] = t == 19;
            ev[2] = t == 40;
            ev[1] = (t >= 1 && t <= 20) || (t >= 22 && t <= 41);
            ev[0] = !(ev[5] || ev[4]);
            gv = {f_a_gnt, f_b_gnt, f_a_done, f_b_done, f_busy, f_spi_cs_n};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL fast_gap t=%0d got %b expected %b (gA gB dA dB bsy csn)", t, gv, ev);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if ({f_a_rdata, f_b_rdata} !== {f_eng_rdata, f_eng_rdata}) begin
            errors++;
            $display("FAIL fast_gap_rdata got a=%h b=%h expected %h", f_a_rdata, f_b_rdata, f_eng_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_a5();
        test_tie();
        test_hold_seq();
        test_mid_reset();
        test_random();
        test_fast_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
